// File: rtl/recur_acc_engine_pkg.sv
// Shared definitions for the recurrence accumulator engine.
// Saturating arithmetic is selected at build time with RECUR_ACC_SATURATE_EN.
package recur_acc_engine_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    localparam string SAT_MACRO = "RECUR_ACC_SATURATE_EN";

endpackage

// File: rtl/recur_acc_step.sv
// One recurrence step: next acc, next y and the step's overflow indication.
// With RECUR_ACC_SATURATE_EN defined, results clamp to 2^W-1; otherwise they wrap and ovf is 0.
module recur_acc_step #(
    parameter int W     = 32,
    parameter int SHIFT = 1
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] x_i,
    input  logic         first_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] y_o,
    output logic         ovf_o
);

`ifdef RECUR_ACC_SATURATE_EN
    // Wide enough that neither the shift nor the two adds can lose bits.
    localparam int WW = W + SHIFT + 2;
    localparam logic [WW-1:0] MAXV = WW'({W{1'b1}});

    logic [WW-1:0] acc_w;
    logic [WW-1:0] y_w;
    logic          acc_of;
    logic          y_of;

    always_comb begin
        acc_w  = WW'(acc_i) + WW'(x_i);
        acc_of = (acc_w > MAXV);
        acc_o  = acc_of ? {W{1'b1}} : acc_w[W-1:0];
        y_w    = (WW'(y_i) << SHIFT) + WW'(acc_o) + WW'(first_i);
        y_of   = (y_w > MAXV);
        y_o    = y_of ? {W{1'b1}} : y_w[W-1:0];
        ovf_o  = acc_of | y_of;
    end
`else
    always_comb begin
        acc_o = acc_i + x_i;
        y_o   = (y_i << SHIFT) + acc_o + W'(first_i);
        ovf_o = 1'b0;
    end
`endif

endmodule

// File: rtl/recur_acc_engine.sv
// Programmable recurrence accumulator: y_k = (y_{k-1} << SHIFT) + acc_k + (k==1), one sample per step.
// Build option RECUR_ACC_SATURATE_EN enables clamping arithmetic and the sticky ovf flag.
module recur_acc_engine
    import recur_acc_engine_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 7,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic [W-1:0]     x,
    input  logic             x_valid,
    output logic             busy,
    output logic [W-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             ovf
);

    state_e           state_q;
    logic [W-1:0]     acc_q, y_q;
    logic [W-1:0]     acc_d, y_d;
    logic [CNT_W-1:0] cnt_q, n_lat_q;
    logic             ovf_q, busy_q, y_valid_q;
    logic             step_ovf;
    logic             first_step, last_step;

    assign first_step = (cnt_q == '0);
    // cnt_q < n_lat_q while running, so the increment cannot wrap.
    assign last_step  = ((cnt_q + CNT_W'(1)) == n_lat_q);

    recur_acc_step #(
        .W     (W),
        .SHIFT (SHIFT)
    ) u_step (
        .acc_i   (acc_q),
        .y_i     (y_q),
        .x_i     (x),
        .first_i (first_step),
        .acc_o   (acc_d),
        .y_o     (y_d),
        .ovf_o   (step_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            n_lat_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_lat_q <= n_iter;
                        acc_q   <= '0;
                        y_q     <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        if (n_iter == '0) begin
                            state_q   <= DONE;
                            y_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (x_valid) begin
                        acc_q <= acc_d;
                        y_q   <= y_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        ovf_q <= ovf_q | step_ovf;
                        if (last_step) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            y_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (y_ready) begin
                        state_q   <= IDLE;
                        y_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign ovf     = ovf_q;

endmodule
